// File: rtl/av_cmd_pkg.sv
// av_cmd_pkg: shared opcodes, response codes and FSM state type for the byte-command Avalon master
package av_cmd_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BE,
        S_ADDR,
        S_DATA,
        S_ISSUE,
        S_WAIT_RD,
        S_RSP,
        S_ERR
    } cmd_state_t;

endpackage

// File: rtl/av_byte_serializer.sv
// av_byte_serializer: parallel load of up to DW/8 bytes, shifted out MSB first on a valid/ready stream
module av_byte_serializer #(
    parameter int DW = 32,
    parameter int CW = $clog2(DW / 8) + 1
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [CW-1:0] load_cnt,
    output logic [7:0]    data,
    output logic          valid,
    input  logic          ready,
    output logic          done
);

    logic [DW-1:0] sr;
    logic [CW-1:0] cnt;
    logic          fire;

    assign data  = sr[DW-1 -: 8];
    assign valid = cnt != '0;
    assign fire  = valid & ready;
    assign done  = fire & (cnt == CW'(1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= load_data;
            cnt <= load_cnt;
        end else if (fire) begin
            sr  <= sr << 8;
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/av_byte_cmd_master.sv
// av_byte_cmd_master: parses framed byte commands into single-beat Avalon-MM accesses and streams back the response
module av_byte_cmd_master
    import av_cmd_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 16,
    parameter int RD_LATENCY  = 1,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic [7:0]      cmd_data_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    output logic [7:0]      rsp_data_o,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [AW-1:0]   avm_address,
    output logic [DW/8-1:0] avm_byteenable,
    output logic            avm_write,
    output logic [DW-1:0]   avm_writedata,
    output logic            avm_read,
    input  logic [DW-1:0]   avm_readdata,
    output logic            frame_err_o
);

    localparam int BEW = DW / 8;
    localparam int BCW = $clog2((AW > DW ? AW : DW) / 8) + 1;
    localparam int SCW = $clog2(BEW) + 1;
    localparam int LCW = $clog2(RD_LATENCY + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    cmd_state_t     state, next;
    logic           wr;
    logic [BEW-1:0] be_sr;
    logic [AW-1:0]  addr_sr, addr_nxt;
    logic [DW-1:0]  data_sr, data_nxt;
    logic [BCW-1:0] bcnt;
    logic [LCW-1:0] lat_cnt;
    logic [TCW-1:0] tmo_cnt;
    logic           acc, in_frame, tmo;
    logic           ser_load, ser_done;
    logic [DW-1:0]  ser_data;
    logic [SCW-1:0] ser_cnt;

    assign acc       = cmd_valid_i & cmd_ready_o;
    assign in_frame  = state inside {S_BE, S_ADDR, S_DATA};
    assign tmo       = in_frame & ~cmd_valid_i & (tmo_cnt == TCW'(TIMEOUT_CYC - 1));
    // Look-ahead values so the Avalon outputs can be loaded on the same edge the last byte lands
    assign addr_nxt  = (state == S_ADDR && acc) ? (addr_sr << 8) | AW'(cmd_data_i) : addr_sr;
    assign data_nxt  = (state == S_DATA && acc) ? (data_sr << 8) | DW'(cmd_data_i) : data_sr;
    assign avm_write = (state == S_ISSUE) & wr;
    assign avm_read  = (state == S_ISSUE) & ~wr;
    assign frame_err_o = (state == S_ERR) | tmo;

    always_comb begin
        next     = state;
        ser_load = 1'b0;
        ser_data = '0;
        ser_cnt  = SCW'(1);
        unique case (state)
            S_IDLE:  next = !acc ? S_IDLE : (cmd_data_i == OP_WR || cmd_data_i == OP_RD) ? S_BE : S_ERR;
            S_BE:    next = tmo ? S_IDLE : acc ? S_ADDR : S_BE;
            S_ADDR:  next = tmo ? S_IDLE : !(acc && bcnt == BCW'(AW / 8 - 1)) ? S_ADDR : wr ? S_DATA : S_ISSUE;
            S_DATA:  next = tmo ? S_IDLE : (acc && bcnt == BCW'(BEW - 1)) ? S_ISSUE : S_DATA;
            S_ISSUE: begin
                next     = wr ? S_RSP : S_WAIT_RD;
                ser_load = wr;
                ser_data = DW'(RSP_ACK) << (DW - 8);
            end
            S_WAIT_RD: begin
                ser_load = lat_cnt == LCW'(RD_LATENCY - 1);
                next     = ser_load ? S_RSP : S_WAIT_RD;
                ser_data = avm_readdata;
                ser_cnt  = SCW'(BEW);
            end
            S_RSP:   next = ser_done ? S_IDLE : S_RSP;
            S_ERR: begin
                next     = S_RSP;
                ser_load = 1'b1;
                ser_data = DW'(RSP_ERR) << (DW - 8);
            end
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state          <= S_IDLE;
            cmd_ready_o    <= 1'b0;
            wr             <= 1'b0;
            be_sr          <= '0;
            addr_sr        <= '0;
            data_sr        <= '0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
            bcnt           <= '0;
            lat_cnt        <= '0;
            tmo_cnt        <= '0;
        end else begin
            state       <= next;
            cmd_ready_o <= next inside {S_IDLE, S_BE, S_ADDR, S_DATA};
            if (state == S_IDLE && acc) wr <= cmd_data_i == OP_WR;
            if (state == S_BE && acc) be_sr <= cmd_data_i[BEW-1:0];
            addr_sr <= addr_nxt;
            data_sr <= data_nxt;
            if (next == S_ISSUE) begin
                avm_address    <= addr_nxt;
                avm_byteenable <= be_sr;
                avm_writedata  <= data_nxt;
            end
            bcnt    <= (next != state) ? '0 : bcnt + BCW'(acc);
            lat_cnt <= (state == S_WAIT_RD && next == S_WAIT_RD) ? lat_cnt + 1'b1 : '0;
            tmo_cnt <= (in_frame && !cmd_valid_i) ? tmo_cnt + 1'b1 : '0;
        end
    end

    av_byte_serializer #(.DW(DW), .CW(SCW)) u_ser (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load      (ser_load),
        .load_data (ser_data),
        .load_cnt  (ser_cnt),
        .data      (rsp_data_o),
        .valid     (rsp_valid_o),
        .ready     (rsp_ready_i),
        .done      (ser_done)
    );

endmodule
